// File: rtl/game_event_ctrl.sv
// Game event initiator: debounces start/restart buttons and qualifies collision into
// single-cycle start_game / restart / game_over pulses against the current game_state state.
module game_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_W            = 20,
    parameter int GRACE_CYCLES    = 25_000_000,
    parameter int GR_W            = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_restart,
    input  logic       collision,
    input  logic [1:0] state,
    output logic       start_game,
    output logic       restart,
    output logic       game_over
);

    localparam logic [1:0]      ST_IDLE    = 2'b00;
    localparam logic [1:0]      ST_PLAYING = 2'b01;
    localparam logic [1:0]      ST_OVER    = 2'b10;
    localparam logic [1:0]      ST_ILLEGAL = 2'b11;
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GR_W-1:0] GR_LOAD    = GR_W'(GRACE_CYCLES);

    // Bit 0 is the start button, bit 1 the restart button.
    logic [1:0]      btn_raw;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      db_level;
    logic [1:0]      db_prev;
    logic [1:0]      req;
    logic [DB_W-1:0] cnt [2];

    logic [1:0]      prev_state;
    logic [GR_W-1:0] grace_cnt;
    logic            go_sent;

    logic            is_playing;
    logic            fresh_entry;
    logic            start_fire;
    logic            restart_fire;
    logic            go_fire;

    assign btn_raw = {btn_restart, btn_start};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            db_level <= '0;
            db_prev  <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else begin
            s1      <= btn_raw;
            s2      <= s1;
            db_prev <= db_level;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db_level[i] <= s2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign req = db_level & ~db_prev;

    always_comb begin
        is_playing   = (state == ST_PLAYING);
        fresh_entry  = is_playing && (prev_state != ST_PLAYING);
        start_fire   = req[0] && (state == ST_IDLE);
        restart_fire = req[1] && ((state == ST_PLAYING) || (state == ST_OVER));
        // Restart wins a same-cycle tie; the collision is picked up next cycle if still playing.
        go_fire      = is_playing && !fresh_entry && (grace_cnt == '0) &&
                       collision && !go_sent && !restart_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state <= ST_IDLE;
            grace_cnt  <= '0;
            go_sent    <= 1'b0;
            start_game <= 1'b0;
            restart    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            prev_state <= state;
            if (state == ST_ILLEGAL) begin
                grace_cnt <= '0;
            end else if (fresh_entry) begin
                grace_cnt <= GR_LOAD;
            end else if (grace_cnt != '0) begin
                grace_cnt <= grace_cnt - GR_W'(1);
            end
            if (!is_playing) begin
                go_sent <= 1'b0;
            end else if (go_fire) begin
                go_sent <= 1'b1;
            end
            start_game <= start_fire;
            restart    <= restart_fire;
            game_over  <= go_fire;
        end
    end

endmodule

// File: tb/tb_game_event_ctrl.sv
// Bench for game_event_ctrl: directed scenarios with a sample-history reference model
// compared every cycle, plus literal pulse-timing and pulse-count expectations.
module tb_game_event_ctrl;

    localparam int D = 4;
    localparam int G = 8;

    logic       clk;
    logic       rst_n;
    logic       btn_start;
    logic       btn_restart;
    logic       collision;
    logic [1:0] state;
    logic       start_game;
    logic       restart;
    logic       game_over;

    game_event_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .DB_W(3),
        .GRACE_CYCLES(G),
        .GR_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_start(btn_start),
        .btn_restart(btn_restart),
        .collision(collision),
        .state(state),
        .start_game(start_game),
        .restart(restart),
        .game_over(game_over)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cnt_start = 0, cnt_restart = 0, cnt_go = 0;
    int last_start_cyc = -1, last_restart_cyc = -1, last_go_cyc = -1;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw button samples per edge; the debounced level flips once the button value seen
    // two edges late has disagreed with it for D consecutive edges.
    bit   hist_s[$];
    bit   hist_r[$];
    bit   m_db_s, m_db_s_prev, m_db_r, m_db_r_prev;
    logic [1:0] m_prev_state;
    int   play_run;
    bit   round_done;
    bit   exp_start, exp_restart, exp_go;

    function automatic bit settled_other(input bit q[$], input bit lvl);
        int n = q.size();
        for (int i = 0; i < D; i++) begin
            if (q[n-3-i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        hist_s.delete();
        hist_r.delete();
        for (int i = 0; i < D + 2; i++) begin
            hist_s.push_back(1'b0);
            hist_r.push_back(1'b0);
        end
        m_db_s = 0; m_db_s_prev = 0; m_db_r = 0; m_db_r_prev = 0;
        m_prev_state = 2'b00;
        play_run = 0;
        round_done = 0;
        exp_start = 0; exp_restart = 0; exp_go = 0;
    endtask

    task automatic model_step();
        bit rise_s, rise_r;
        rise_s = m_db_s && !m_db_s_prev;
        rise_r = m_db_r && !m_db_r_prev;
        if (state == 2'b01) play_run = (m_prev_state == 2'b01) ? play_run + 1 : 1;
        else play_run = 0;
        exp_start   = rise_s && (state == 2'b00);
        exp_restart = rise_r && (state == 2'b01 || state == 2'b10);
        exp_go      = (state == 2'b01) && (play_run >= G + 2) && collision &&
                      !round_done && !exp_restart;
        if (state != 2'b01) round_done = 0;
        else if (exp_go) round_done = 1;
        m_db_s_prev = m_db_s;
        m_db_r_prev = m_db_r;
        hist_s.push_back(btn_start);
        hist_r.push_back(btn_restart);
        while (hist_s.size() > 40) void'(hist_s.pop_front());
        while (hist_r.size() > 40) void'(hist_r.pop_front());
        if (settled_other(hist_s, m_db_s)) m_db_s = !m_db_s;
        if (settled_other(hist_r, m_db_r)) m_db_r = !m_db_r;
        m_prev_state = state;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else model_step();
        end
    end

    // ---------------- compare ----------------
    initial forever begin
        @(negedge clk);
        check("start_game", int'(start_game), int'(exp_start));
        check("restart", int'(restart), int'(exp_restart));
        check("game_over", int'(game_over), int'(exp_go));
        if (start_game) begin cnt_start++; last_start_cyc = cyc; end
        if (restart) begin cnt_restart++; last_restart_cyc = cyc; end
        if (game_over) begin cnt_go++; last_go_cyc = cyc; end
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input bit which, input int hold, input int rel);
        if (which) btn_restart = 1'b1; else btn_start = 1'b1;
        step(hold);
        if (which) btn_restart = 1'b0; else btn_start = 1'b0;
        step(rel);
    endtask

    int c0, c1, b_s, b_r, b_g;

    initial begin
        rst_n = 1'b0; btn_start = 0; btn_restart = 0; collision = 0; state = 2'b00;
        #1;
        check("reset_start", int'(start_game), 0);
        check("reset_restart", int'(restart), 0);
        check("reset_go", int'(game_over), 0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // 1: clean start press in IDLE
        b_s = cnt_start; b_r = cnt_restart; b_g = cnt_go;
        c0 = cyc;
        press(0, 12, 12);
        check("s1_start_count", cnt_start - b_s, 1);
        check("s1_start_cycle", last_start_cyc, c0 + 7);
        check("s1_other_count", (cnt_restart - b_r) + (cnt_go - b_g), 0);

        // 2: 3-cycle glitch rejected, then clean press accepted
        b_s = cnt_start;
        press(0, 3, 10);
        check("s2_glitch_count", cnt_start - b_s, 0);
        press(0, 12, 12);
        check("s2_clean_count", cnt_start - b_s, 1);

        // 3: start dropped outside IDLE; restart only in PLAYING/OVER
        b_s = cnt_start; b_r = cnt_restart;
        state = 2'b01; step(2);
        press(0, 12, 12);
        state = 2'b10; step(2);
        press(0, 12, 12);
        check("s3_start_dropped", cnt_start - b_s, 0);
        press(1, 12, 12);
        check("s3_restart_over", cnt_restart - b_r, 1);
        state = 2'b00; step(2);
        press(1, 12, 12);
        check("s3_restart_idle", cnt_restart - b_r, 1);

        // 4: grace window then one game_over per round
        b_g = cnt_go;
        collision = 1'b1; step(3);
        c0 = cyc;
        state = 2'b01;
        step(70);
        check("s4_go_cycle", last_go_cyc, c0 + 10);
        check("s4_go_count", cnt_go - b_g, 1);
        state = 2'b10; step(3);
        state = 2'b00; step(3);
        c1 = cyc;
        state = 2'b01;
        step(20);
        check("s4_rearm_cycle", last_go_cyc, c1 + 10);
        check("s4_rearm_count", cnt_go - b_g, 2);
        collision = 1'b0;

        // 5: restart beats game_over in the same cycle
        state = 2'b10; step(2);
        state = 2'b01; step(15);
        c0 = cyc;
        btn_restart = 1'b1;
        step(6);
        collision = 1'b1;
        step(1);
        check("s5_restart_hi", int'(restart), 1);
        check("s5_go_suppressed", int'(game_over), 0);
        check("s5_restart_cycle", last_restart_cyc, c0 + 7);
        step(1);
        check("s5_go_next", int'(game_over), 1);
        collision = 1'b0;
        btn_restart = 1'b0;
        step(12);
        state = 2'b10; step(2);

        // 6: reset mid-debounce aborts; held press after reset gives one pulse
        state = 2'b00; step(2);
        b_s = cnt_start;
        btn_start = 1'b1;
        step(4);
        rst_n = 1'b0;
        #1;
        check("s6_rst_start", int'(start_game), 0);
        check("s6_rst_restart", int'(restart), 0);
        check("s6_rst_go", int'(game_over), 0);
        step(2);
        rst_n = 1'b1;
        c0 = cyc;
        step(14);
        check("s6_start_count", cnt_start - b_s, 1);
        check("s6_start_cycle", last_start_cyc, c0 + 7);
        btn_start = 1'b0;
        step(12);
        check("s6_release_count", cnt_start - b_s, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
